// File: rtl/adder_arbiter_if.sv
// Request/result bundle between the two operand-loading requesters and the
// arbiter that shares one 32-bit carry-lookahead adder between them.
interface adder_arbiter_if #(parameter int WIDTH = 32);
    logic             req0, cin0, req1, cin1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1, done0, done1;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, busy;

    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1,
        input  gnt0, gnt1, done0, done1, sum, cout, ovf, busy
    );

    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1,
        output gnt0, gnt1, done0, done1, sum, cout, ovf, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of a shared 32-bit carry-lookahead adder:
// captures the winner's operands, adds them, and returns a registered result.

module carry_lookahead_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] p, g;
    logic        cg, gg, gp;

    // 4-bit lookahead groups; each bit's carry is the group prefix G/P
    // applied to the carry entering the group.
    always_comb begin
        // NOTE: every combinational variable gets a value before any branch or
        // loop so no path can leave it unassigned and infer a latch.
        p   = a ^ b;
        g   = a & b;
        sum = '0;
        cg  = cin;
        gg  = 1'b0;
        gp  = 1'b1;
        for (int grp = 0; grp < 8; grp++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int k = 0; k < 4; k++) begin
                sum[4*grp+k] = p[4*grp+k] ^ (gg | (gp & cg));
                gg = g[4*grp+k] | (p[4*grp+k] & gg);
                gp = gp & p[4*grp+k];
            end
            cg = gg | (gp & cg);
        end
        cout = cg;
    end
endmodule

module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             rr, owner, win, any_req;
    logic [WIDTH-1:0] op_a, op_b, sum_r, add_sum;
    logic             cin_r, cout_r, ovf_r, add_cout;

    always_comb begin
        any_req    = bus.req0 | bus.req1;
        win        = (bus.req0 && bus.req1) ? rr : bus.req1;
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = CALC;
            CALC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples the values that existed before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= 1'b0;
            owner  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            cin_r  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (any_req) begin
                    owner <= win;
                    op_a  <= win ? bus.a1   : bus.a0;
                    op_b  <= win ? bus.b1   : bus.b0;
                    cin_r <= win ? bus.cin1 : bus.cin0;
                end
                CALC: begin
                    sum_r  <= add_sum;
                    cout_r <= add_cout;
                    ovf_r  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                              (add_sum[WIDTH-1] != op_a[WIDTH-1]);
                end
                DONE:    rr <= ~owner;
                default: ;
            endcase
        end
    end

    // Only registered operands reach the adder, so it never sees them move mid-add.
    carry_lookahead_adder u_cla (
        .a    (op_a),
        .b    (op_b),
        .cin  (cin_r),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign bus.gnt0  = (state == CALC) && !owner;
    assign bus.gnt1  = (state == CALC) &&  owner;
    assign bus.done0 = (state == DONE) && !owner;
    assign bus.done1 = (state == DONE) &&  owner;
    assign bus.busy  = (state != IDLE);
    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;
    assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level reference model with a per-cycle
// compare process, directed scenarios with literal results, then random traffic.
module tb_adder_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    bit   cmp_en = 1'b0;

    adder_arbiter_if #(.WIDTH(32)) bus ();

    adder_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [38:0] all_outs();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.cout, bus.ovf, bus.sum};
    endfunction

    // Reference model: an add granted at edge m_ge shows gnt for one cycle,
    // done plus the new result the next, and the arbiter samples again 3 edges later.
    int          m_e   = 0;
    int          m_ge  = -10;
    bit          m_w   = 1'b0;
    bit          m_rr  = 1'b0;
    logic [31:0] m_sum = '0, p_sum = '0;
    bit          m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
    logic [32:0] m_t;
    longint      m_sv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_ge = -10; m_w = 1'b0; m_rr = 1'b0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else begin
            m_e++;
            if (m_e >= m_ge + 3 && (bus.req0 || bus.req1)) begin
                m_w = (bus.req0 && bus.req1) ? m_rr : bus.req1;
                if (m_w) begin
                    m_t  = {1'b0, bus.a1} + {1'b0, bus.b1} + 33'(bus.cin1);
                    m_sv = longint'($signed(bus.a1)) + longint'($signed(bus.b1)) + longint'(bus.cin1);
                end else begin
                    m_t  = {1'b0, bus.a0} + {1'b0, bus.b0} + 33'(bus.cin0);
                    m_sv = longint'($signed(bus.a0)) + longint'($signed(bus.b0)) + longint'(bus.cin0);
                end
                {p_cout, p_sum} = m_t;
                p_ovf = (m_sv > 64'sd2147483647) || (m_sv < -64'sd2147483648);
                m_ge  = m_e;
                m_rr  = ~m_w;
            end
            if (m_e == m_ge + 1) begin
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ctrl", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy},
                  {(m_e == m_ge) && !m_w, (m_e == m_ge) && m_w,
                   (m_e == m_ge + 1) && !m_w, (m_e == m_ge + 1) && m_w,
                   (m_e == m_ge) || (m_e == m_ge + 1)});
            check("result", {bus.cout, bus.ovf, bus.sum}, {m_cout, m_ovf, m_sum});
        end
    end

    // which: 0 gnt0, 1 gnt1, 2 done0, 3 done1; cycles counts negedges waited
    task automatic wait_for(input int which, input string name, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < 20) begin
            @(negedge clk);
            cycles++;
            case (which)
                0:       found = bus.gnt0;
                1:       found = bus.gnt1;
                2:       found = bus.done0;
                default: found = bus.done1;
            endcase
        end
        check(name, 64'(found), 64'd1);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        int n_done;
        int order[$];
        int times[$];

        {bus.req0, bus.cin0, bus.req1, bus.cin1} = '0;
        {bus.a0, bus.b0, bus.a1, bus.b1} = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(all_outs()), 64'd0);
        cmp_en = 1'b1;
        #1 rst_n = 1'b1;

        // Single request; operand changed in the gnt cycle must not leak in.
        @(negedge clk);
        #1 bus.req0 = 1'b1; bus.a0 = 32'h5; bus.b0 = 32'h3; bus.cin0 = 1'b1;
        wait_for(0, "gnt0_single", cyc);
        check("gnt0_latency", 64'(cyc), 64'd1);
        #1 bus.req0 = 1'b0; bus.a0 = 32'hDEAD_BEEF;
        wait_for(2, "done0_single", cyc);
        check("done0_latency", 64'(cyc), 64'd1);
        check("single_result", {bus.cout, bus.ovf, bus.sum}, {2'b00, 32'h0000_0009});

        // Carry out, then signed overflow, from requester 1.
        #1 bus.req1 = 1'b1; bus.a1 = 32'hFFFF_FFFF; bus.b1 = 32'h1; bus.cin1 = 1'b0;
        wait_for(1, "gnt1_carry", cyc);
        #1 bus.req1 = 1'b0;
        wait_for(3, "done1_carry", cyc);
        check("carry_result", {bus.cout, bus.ovf, bus.sum}, {2'b10, 32'h0000_0000});
        #1 bus.req1 = 1'b1; bus.a1 = 32'h7FFF_FFFF; bus.b1 = 32'h1;
        wait_for(1, "gnt1_ovf", cyc);
        #1 bus.req1 = 1'b0;
        wait_for(3, "done1_ovf", cyc);
        check("ovf_result", {bus.cout, bus.ovf, bus.sum}, {2'b01, 32'h8000_0000});

        // Reset during CALC aborts the add; no done afterwards.
        #1 bus.req0 = 1'b1; bus.a0 = 32'h1234_5678; bus.b0 = 32'h1111_1111; bus.cin0 = 1'b0;
        wait_for(0, "gnt0_abort", cyc);
        #1 rst_n = 1'b0; bus.req0 = 1'b0;
        #1 check("reset_mid_calc", 64'(all_outs()), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        n_done = 0;
        repeat (6) begin
            @(negedge clk);
            n_done += int'(bus.done0 | bus.done1);
        end
        check("no_done_after_abort", 64'(n_done), 64'd0);

        // Both requesting from reset: strict alternation, one grant per 3 cycles.
        #1 rst_n = 1'b0;
        bus.req0 = 1'b1; bus.a0 = 32'h0000_1000; bus.b0 = 32'h0000_0234; bus.cin0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 32'hA000_0000; bus.b1 = 32'hA000_0000; bus.cin1 = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                order.push_back(bus.gnt1 ? 1 : 0);
                times.push_back(i);
            end
        end
        #1 bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("rr_grant_count", 64'(order.size()), 64'd5);
        if (order.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("rr_order", 64'(order[i]), 64'(i % 2));
                if (i > 0) check("rr_spacing", 64'(times[i] - times[i-1]), 64'd3);
            end
        end
        repeat (4) @(negedge clk);

        // Late request during CALC waits for the next IDLE edge; sum holds meanwhile.
        #1 bus.req0 = 1'b1; bus.a0 = 32'd100; bus.b0 = 32'd23; bus.cin0 = 1'b0;
        wait_for(0, "gnt0_late", cyc);
        #1 bus.req0 = 1'b0; bus.req1 = 1'b1; bus.a1 = 32'd1; bus.b1 = 32'd1; bus.cin1 = 1'b0;
        wait_for(1, "gnt1_late", cyc);
        check("late_wait", 64'(cyc), 64'd3);
        check("sum_held", 64'(bus.sum), 64'd123);
        #1 bus.req1 = 1'b0;
        wait_for(3, "done1_late", cyc);
        check("late_result", 64'(bus.sum), 64'd2);

        // Random traffic, checked every cycle by the compare process.
        repeat (400) begin
            @(negedge clk);
            #1;
            bus.req0 = ($urandom_range(0, 99) < 55);
            bus.req1 = ($urandom_range(0, 99) < 55);
            bus.a0 = rand_op(); bus.b0 = rand_op(); bus.cin0 = 1'($urandom);
            bus.a1 = rand_op(); bus.b1 = rand_op(); bus.cin1 = 1'($urandom);
        end
        #1 bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
